// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets N_REQ byte sources share one UART transmitter.
// It also contains the baud tick generator and the per-frame tx_done watchdog.
module uart_tx_arb #(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] data,
    output logic [N_REQ-1:0]   gnt,
    output logic               tx_wr_en,
    output logic [7:0]         tx_d,
    output logic               baud_trig,
    input  logic               tx_done,
    output logic               busy,
    output logic               timeout_err
);

    // state     | meaning
    // S_IDLE    | no frame in flight; round-robin pick among req
    // S_ISSUE   | grant pulse visible, byte latched, write strike queued
    // S_WAIT_DONE | write strike visible on entry; wait for tx_done or timeout
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_BITS + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_BITS);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_REQ - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    win_q, win_d;
    logic [7:0]       byte_q, byte_d;
    logic [BW-1:0]    baud_cnt_q, baud_cnt_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             wr_q, wr_d;

    logic             baud_tick;
    logic             found;
    logic [IW-1:0]    pick;
    logic [IW:0]      sum;
    logic [IW-1:0]    cand;
    logic [IW-1:0]    next_ptr;

    assign baud_tick  = (baud_cnt_q == BAUD_LAST);
    assign baud_cnt_d = baud_tick ? '0 : baud_cnt_q + 1'b1;

    // Scan from ptr upward, wrapping modulo N_REQ; first active request wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(i);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign next_ptr = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        byte_d      = byte_q;
        to_cnt_d    = to_cnt_q;
        gnt_d       = '0;
        wr_d        = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = N_REQ'(1) << pick;
                    win_d   = pick;
                    byte_d  = data[8*int'(pick) +: 8];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wr_d     = 1'b1;
                to_cnt_d = TO_LOAD;
                state_d  = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A frame completing on the same tick as expiry counts as done.
                if (tx_done) begin
                    ptr_d   = next_ptr;
                    state_d = S_IDLE;
                end else if (baud_tick) begin
                    if (to_cnt_q == TW'(1)) begin
                        timeout_err = rst;
                        ptr_d       = next_ptr;
                        state_d     = S_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            byte_q     <= '0;
            baud_cnt_q <= '0;
            to_cnt_q   <= '0;
            gnt_q      <= '0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            byte_q     <= byte_d;
            baud_cnt_q <= baud_cnt_d;
            to_cnt_q   <= to_cnt_d;
            gnt_q      <= gnt_d;
            wr_q       <= wr_d;
        end
    end

    assign gnt       = gnt_q;
    assign tx_wr_en  = wr_q;
    assign busy      = (state_q != S_IDLE);
    assign tx_d      = busy ? byte_q : 8'h00;
    assign baud_trig = rst & baud_tick;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: table of frames checked through a grant/byte scoreboard,
// plus hand sequences for baud phase, idle, timeout tie and mid-frame reset.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [31:0] data = 32'h0;
    logic        tx_done = 1'b0;
    logic [3:0]  gnt;
    logic        tx_wr_en;
    logic [7:0]  tx_d;
    logic        baud_trig;
    logic        busy;
    logic        timeout_err;

    uart_tx_arb #(.N_REQ(4), .CLKS_PER_BIT(16), .TIMEOUT_BITS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data        (data),
        .gnt         (gnt),
        .tx_wr_en    (tx_wr_en),
        .tx_d        (tx_d),
        .baud_trig   (baud_trig),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // mode: 0 = tx_done returned, 1 = let it time out, 2 = tx_done on the expiry tick
    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          mode;
        int          win;
        bit          glitch;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] b;
    } sb_t;

    int   tests = 0;
    int   fails = 0;
    sb_t  exp_q[$];
    sb_t  mon_e;
    logic [7:0] exp_byte = 8'h00;
    bit   pending_wr = 1'b0;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (gnt !== 4'b0) begin
                check("gnt_onehot", $countones(gnt), 1);
                if (exp_q.size() == 0) begin
                    check("gnt_unexpected", {28'h0, gnt}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("gnt_sb", {28'h0, gnt}, {28'h0, mon_e.gnt});
                    exp_byte   = mon_e.b;
                    pending_wr = 1'b1;
                end
            end
            if (tx_wr_en === 1'b1) begin
                check("wr_expected", {31'h0, pending_wr}, 1);
                check("tx_d_sb", {24'h0, tx_d}, {24'h0, exp_byte});
                pending_wr = 1'b0;
            end
        end
    end

    task automatic wait_gnt(output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            lat = k;
            if (gnt !== 4'b0) begin
                got = 1'b1;
                break;
            end
        end
        check("gnt_seen", {31'h0, got}, 1);
        check("gnt_latency", lat, 0);
    endtask

    task automatic run_frame(input vec_t v);
        sb_t  e;
        bit   got;
        int   lat;
        int   ticks;
        logic [7:0] b;
        b     = v.data[8*v.win +: 8];
        e.gnt = 4'(1 << v.win);
        e.b   = b;
        exp_q.push_back(e);
        req  = v.req;
        data = v.data;
        wait_gnt(got, lat);
        check("busy_issue", {31'h0, busy}, 1);
        req = 4'b0;
        @(negedge clk);
        check("wr_next", {31'h0, tx_wr_en}, 1);
        ticks = 0;
        got   = 1'b0;
        if (v.mode == 0) begin
            if (v.glitch) req = 4'b1111;
            repeat (2) @(negedge clk);
            req = 4'b0;
            @(negedge clk);
            tx_done = 1'b1;
            #1;
            check("tx_d_hold", {24'h0, tx_d}, {24'h0, b});
            check("busy_wait", {31'h0, busy}, 1);
            @(negedge clk);
            tx_done = 1'b0;
            check("done_idle", {31'h0, busy}, 0);
            check("done_txd0", {24'h0, tx_d}, 0);
            if (v.glitch) begin
                repeat (3) begin
                    @(negedge clk);
                    check("dropped_req", {28'h0, gnt}, 0);
                end
            end
        end else if (v.mode == 1) begin
            for (int k = 0; k < 400; k++) begin
                if (k > 0) @(negedge clk);
                if (baud_trig) ticks++;
                if (timeout_err) begin
                    got = 1'b1;
                    break;
                end
            end
            check("to_seen", {31'h0, got}, 1);
            check("to_ticks", ticks, 16);
            @(negedge clk);
            check("to_idle", {31'h0, busy}, 0);
            check("to_pulse", {31'h0, timeout_err}, 0);
        end else begin
            for (int k = 0; k < 400; k++) begin
                if (k > 0) @(negedge clk);
                if (baud_trig) ticks++;
                if (timeout_err) got = 1'b1;
                if (ticks == 15) break;
            end
            check("tie_early_to", {31'h0, got}, 0);
            repeat (16) @(negedge clk);
            tx_done = 1'b1;
            #1;
            check("tie_tick", {31'h0, baud_trig}, 1);
            check("tie_no_to", {31'h0, timeout_err}, 0);
            @(negedge clk);
            tx_done = 1'b0;
            check("tie_idle", {31'h0, busy}, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t e;
        bit  got;
        int  lat;

        vecs[0]  = '{4'b1111, 32'h44332211, 0, 0, 1'b0};
        vecs[1]  = '{4'b1111, 32'h44332211, 0, 1, 1'b0};
        vecs[2]  = '{4'b1111, 32'h44332211, 0, 2, 1'b0};
        vecs[3]  = '{4'b1111, 32'h44332211, 0, 3, 1'b0};
        vecs[4]  = '{4'b1111, 32'h8877665F, 0, 0, 1'b0};
        vecs[5]  = '{4'b0100, 32'h3CA57E81, 0, 2, 1'b0};
        vecs[6]  = '{4'b1001, 32'hF00DBEEF, 0, 3, 1'b0};
        vecs[7]  = '{4'b1001, 32'hF00DBEEF, 0, 0, 1'b0};
        vecs[8]  = '{4'b0010, 32'h00C30000, 1, 1, 1'b0};
        vecs[9]  = '{4'b0110, 32'h12345678, 0, 2, 1'b0};
        vecs[10] = '{4'b1010, 32'h9ABCDEF0, 2, 3, 1'b0};
        vecs[11] = '{4'b0110, 32'h0055AA00, 0, 1, 1'b1};
        vecs[12] = '{4'b1011, 32'h7F000000, 0, 3, 1'b0};
        vecs[13] = '{4'b0101, 32'h00E100FE, 0, 0, 1'b0};
        vecs[14] = '{4'b1001, 32'h6600004D, 0, 0, 1'b0};
        vecs[15] = '{4'b0010, 32'h00005A00, 0, 1, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_gnt", {28'h0, gnt}, 0);
        check("rst_wr", {31'h0, tx_wr_en}, 0);
        check("rst_txd", {24'h0, tx_d}, 0);
        check("rst_baud", {31'h0, baud_trig}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_to", {31'h0, timeout_err}, 0);
        rst = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            check($sformatf("baud_c%0d", k), {31'h0, baud_trig}, ((k % 16) == 15) ? 1 : 0);
        end

        for (int i = 0; i <= 13; i++) run_frame(vecs[i]);

        req = 4'b0;
        for (int k = 0; k < 4; k++) begin
            tx_done = (k == 1);
            @(negedge clk);
            check("idle_gnt", {28'h0, gnt}, 0);
            check("idle_busy", {31'h0, busy}, 0);
        end
        tx_done = 1'b0;

        e.gnt = 4'b0100;
        e.b   = 8'hC7;
        exp_q.push_back(e);
        req  = 4'b1100;
        data = 32'h11C73355;
        wait_gnt(got, lat);
        req = 4'b0;
        @(negedge clk);
        check("rst_wr_pre", {31'h0, tx_wr_en}, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_gnt", {28'h0, gnt}, 0);
        check("abort_wr", {31'h0, tx_wr_en}, 0);
        check("abort_txd", {24'h0, tx_d}, 0);
        check("abort_busy", {31'h0, busy}, 0);
        check("abort_to", {31'h0, timeout_err}, 0);
        check("abort_baud", {31'h0, baud_trig}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("release_gnt", {28'h0, gnt}, 0);
        check("release_wr", {31'h0, tx_wr_en}, 0);
        check("sb_empty", exp_q.size(), 0);

        for (int i = 14; i <= 15; i++) run_frame(vecs[i]);

        repeat (2) @(negedge clk);
        check("final_sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per baud period (>=2).
REQ-003 Parameter TIMEOUT_BITS, default 16, baud periods allowed for tx_done after issue.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low (0 = reset).
REQ-006 req  in  N_REQ  per-requester byte-send request; level, held until granted.
REQ-007 data  in  8*N_REQ  byte for requester i on data[8i+7:8i].
REQ-008 gnt  out  N_REQ  one-hot, one-cycle pulse; byte of that requester accepted.
REQ-009 tx_wr_en  out  1  one-cycle write strike to UART transmitter.
REQ-010 tx_d  out  8  byte to UART transmitter.
REQ-011 baud_trig  out  1  one-cycle baud tick to UART transmitter.
REQ-012 tx_done  in  1  transmitter frame-complete pulse.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 timeout_err  out  1  one-cycle pulse when tx_done not seen within TIMEOUT_BITS ticks.

Function
REQ-015 Baud generator SHALL be a free-running counter 0..CLKS_PER_BIT-1; baud_trig=1 exactly in cycles where count==CLKS_PER_BIT-1, then wrap to 0.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_DONE.
REQ-017 IDLE: when any req bit is 1, pick winner by round-robin starting at pointer ptr (lowest index >= ptr, wrapping modulo N_REQ), latch data of winner, pulse gnt[winner], go ISSUE next cycle.
REQ-018 IDLE with req==0: remain IDLE, gnt=0.
REQ-019 ISSUE: tx_wr_en=1 for exactly one cycle with tx_d=latched byte; go WAIT_DONE.
REQ-020 tx_d SHALL hold the latched byte stable from ISSUE through end of WAIT_DONE; 0 in IDLE.
REQ-021 WAIT_DONE: on tx_done=1, ptr<=(winner+1) mod N_REQ, go IDLE; next grant earliest one cycle later.
REQ-022 WAIT_DONE: timeout counter increments per baud_trig; when it reaches TIMEOUT_BITS without tx_done, pulse timeout_err, ptr<=(winner+1) mod N_REQ, go IDLE.
REQ-023 tx_done and the timeout reached in the same cycle: tx_done wins, no timeout_err.
REQ-024 tx_done outside WAIT_DONE SHALL be ignored.
REQ-025 req changes outside IDLE SHALL be ignored; a req dropped before grant is never granted.
REQ-026 At most one gnt bit high in any cycle; at most one grant per frame.
REQ-027 Latency: req rise in IDLE -> gnt same cycle's next edge (1 cycle) -> tx_wr_en following cycle.

Reset
REQ-028 While rst=0 at a clock edge: state<=IDLE, ptr<=0, baud counter<=0, timeout counter<=0, latched byte<=0.
REQ-029 Reset values of outputs: gnt=0, tx_wr_en=0, tx_d=0, baud_trig=0, busy=0, timeout_err=0.
REQ-030 Reset asserted mid-frame SHALL abort immediately; no gnt, tx_wr_en or timeout_err on the release cycle.

Verification
REQ-031 Single requester: req=4'b0100, data[23:16]=8'hA5 -> gnt=4'b0100 one cycle, next cycle tx_wr_en=1 tx_d=8'hA5, busy until tx_done, then ptr=3.
REQ-032 Contention: req=4'b1111 held, tx_done returned each frame -> grant order 0,1,2,3,0; never two gnt bits.
REQ-033 Round-robin wrap: ptr=3, req=4'b1001 -> gnt[3] first, then gnt[0].
REQ-034 Baud: CLKS_PER_BIT=16 -> baud_trig pulses every 16th cycle, first pulse 16 cycles after reset release.
REQ-035 Timeout: tx_done tied 0 after a grant -> timeout_err pulses after 16 baud ticks, FSM to IDLE, next requester served.
REQ-036 Reset in WAIT_DONE -> all outputs 0 next cycle, ptr=0, fresh req=4'b0010 granted normally after release.
